// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_e : MEM-stage access FSM states (IDLE, WAIT, ERR)
//   DATA_W, REG_ADDR_W : datapath and register-index widths
//   wb_t    : contents of the MEM/WB pipeline register
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     alu;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_to_reg;
    logic                  reg_write;
  } wb_t;

endpackage : mips_pkg

// File: rtl/mem_wb.sv
// MEM/WB pipeline register.
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture alu/rd/mem_to_reg/reg_write from EX/MEM
//   load_rdata     : with load, also capture the returned load word
//   bubble         : clear reg_write only, every other field holds
//   *_in           : EX/MEM fields and memory read data
//   wb_*           : registered MEM/WB fields
module mem_wb
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_rdata,
  input  logic                  bubble,
  input  logic [DATA_W-1:0]     alu_in,
  input  logic [DATA_W-1:0]     rdata_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic [DATA_W-1:0]     wb_rdata,
  output logic [DATA_W-1:0]     wb_alu,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write
);

  wb_t wb_q, wb_d;

  // NOTE: assigning wb_d = wb_q first gives every path a value, so no latch is inferred.
  always_comb begin
    wb_d = wb_q;
    if (bubble) begin
      wb_d.reg_write = 1'b0;
    end else if (load) begin
      wb_d.alu        = alu_in;
      wb_d.rd         = rd_in;
      wb_d.mem_to_reg = mem_to_reg_in;
      wb_d.reg_write  = reg_write_in;
      if (load_rdata) wb_d.rdata = rdata_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign wb_rdata      = wb_q.rdata;
  assign wb_alu        = wb_q.alu;
  assign wb_rd         = wb_q.rd;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write  = wb_q.reg_write;

endmodule : mem_wb

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the pipe until the
// memory acknowledges, flags a sticky bus error on timeout, and feeds MEM/WB.
//   clk, rst                : clock, synchronous active-high reset
//   alu_res, st_data, rd    : EX/MEM address/result, store data, destination
//   mem_read .. reg_write   : EX/MEM control bits (write wins over read)
//   dmem_req/we/addr/wdata  : registered data-memory request
//   dmem_ack, dmem_rdata    : memory completion and load data
//   stall                   : hold EX/MEM and earlier stages
//   wb_*                    : MEM/WB register outputs
//   bus_err                 : sticky, set after TIMEOUT cycles without ack
//   misalign                : one-cycle pulse on a misaligned access
// Build option: define MISALIGN_TRAP_EN to trap accesses with alu_res[1:0]!=0
// (no request, bubble into MEM/WB, no stall). Undefined, the low address bits
// are simply dropped and misalign is tied 0.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     wb_rdata,
  output logic [DATA_W-1:0]     wb_alu,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic                  bus_err,
  output logic                  misalign
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic access, misalign_hit;
  logic wb_load, wb_load_rdata, wb_bubble;

  assign access  = mem_read | mem_write;
  assign cnt_inc = cnt_q + 8'd1;

`ifdef MISALIGN_TRAP_EN
  assign misalign_hit = access & (|alu_res[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    stall         = 1'b0;
    misalign      = 1'b0;
    wb_load       = 1'b0;
    wb_load_rdata = 1'b0;
    wb_bubble     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (misalign_hit) begin
          misalign  = 1'b1;
          wb_bubble = 1'b1;
        end else if (access) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_res[DATA_W-1:2], 2'b00};
          wdata_d = st_data;
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          // EX/MEM is still holding the instruction that made the request.
          wb_load       = 1'b1;
          wb_load_rdata = ~we_q;
          req_d         = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            req_d   = 1'b0;
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A held instruction must never reach write-back more than once.
    if (stall) wb_bubble = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = (state_q == ST_ERR);

  mem_wb u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .load         (wb_load),
    .load_rdata   (wb_load_rdata),
    .bubble       (wb_bubble),
    .alu_in       (alu_res),
    .rdata_in     (dmem_rdata),
    .rd_in        (rd),
    .mem_to_reg_in(mem_to_reg),
    .reg_write_in (reg_write),
    .wb_rdata     (wb_rdata),
    .wb_alu       (wb_alu),
    .wb_rd        (wb_rd),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write (wb_reg_write)
  );

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Expected values come from a transaction
// level model: an access waiting d cycles for ack stalls 1+d cycles, requests
// for 1+d cycles, then writes back once; wb_rdata remembers the last load word.
module tb_mem_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res, st_data, dmem_rdata;
  logic [4:0]  rd;
  logic        mem_read, mem_write, mem_to_reg, reg_write, dmem_ack;
  logic        dmem_req, dmem_we, stall, bus_err, misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb_rdata, wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_mem_to_reg, wb_reg_write;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rdata;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_res(alu_res), .st_data(st_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .wb_rdata(wb_rdata),
    .wb_alu(wb_alu), .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic rd_en, input logic wr_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r,
                        input logic m2r, input logic rw);
    mem_read   = rd_en;
    mem_write  = wr_en;
    alu_res    = a;
    st_data    = d;
    rd         = r;
    mem_to_reg = m2r;
    reg_write  = rw;
  endtask

  function automatic logic any_out();
    return |{stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_rdata, wb_alu,
             wb_rd, wb_mem_to_reg, wb_reg_write, bus_err, misalign};
  endfunction

  // Full access: request issued, ack after 'delay' WAIT cycles, single write-back.
  task automatic do_access(input string name, input logic is_wr, input logic is_rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] r, input logic m2r, input logic rw,
                           input int delay, input logic [31:0] rdata);
    int stall_cycles = 0;
    int req_cycles   = 0;
    logic [31:0] exp_addr;
    exp_addr = a & 32'hFFFF_FFFC;
    set_ex(is_rd, is_wr, a, d, r, m2r, rw);
    dmem_ack = 1'b0;
    #1;
    n_tests++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL %s misalign got %b exp 0", name, misalign);
    end
    if (stall) stall_cycles++;
    if (dmem_req) req_cycles++;
    step();
    n_tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write} !== {1'b1, is_wr, exp_addr, d, 1'b0}) begin
      n_fail++;
      $display("FAIL %s request got req=%b we=%b addr=%h wdata=%h wbrw=%b exp req=1 we=%b addr=%h wdata=%h wbrw=0",
               name, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write, is_wr, exp_addr, d);
    end
    for (int k = 0; k < delay; k++) begin
      #1;
      if (stall) stall_cycles++;
      if (dmem_req) req_cycles++;
      step();
      n_tests++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write, bus_err} !== {1'b1, is_wr, exp_addr, d, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d got req=%b we=%b addr=%h wdata=%h wbrw=%b berr=%b",
                 name, k, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write, bus_err);
      end
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1;
    if (stall) stall_cycles++;
    if (dmem_req) req_cycles++;
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    set_ex(1'b0, 1'b0, $urandom, $urandom, 5'd0, 1'b0, 1'b0);
    if (!is_wr) exp_rdata = rdata;
    n_tests++;
    if (stall_cycles !== 1 + delay) begin
      n_fail++; $display("FAIL %s stall_cycles got %0d exp %0d", name, stall_cycles, 1 + delay);
    end
    n_tests++;
    if (req_cycles !== 1 + delay) begin
      n_fail++; $display("FAIL %s req_cycles got %0d exp %0d", name, req_cycles, 1 + delay);
    end
    n_tests++;
    if ({dmem_req, wb_reg_write, wb_rd, wb_alu, wb_mem_to_reg, wb_rdata} !== {1'b0, rw, r, a, m2r, exp_rdata}) begin
      n_fail++;
      $display("FAIL %s writeback got req=%b rw=%b rd=%0d alu=%h m2r=%b rdata=%h exp req=0 rw=%b rd=%0d alu=%h m2r=%b rdata=%h",
               name, dmem_req, wb_reg_write, wb_rd, wb_alu, wb_mem_to_reg, wb_rdata, rw, r, a, m2r, exp_rdata);
    end
    step();
    n_tests++;
    if (wb_reg_write !== 1'b0 || wb_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL %s single_writeback got rw=%b rdata=%h exp rw=0 rdata=%h", name, wb_reg_write, wb_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
    #1;
    exp_rdata = 32'h0;
    n_tests++;
    if (any_out() !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero outputs exp all 0 (wb_alu=%h req=%b)", wb_alu, dmem_req);
    end
  endtask

  task automatic test_alu_op();
    set_ex(1'b0, 1'b0, 32'h10, 32'h0, 5'd3, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL alu_stall got %b exp 0", stall);
    end
    step();
    n_tests++;
    if ({wb_alu, wb_rd, wb_reg_write} !== {32'h10, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL alu_wb got alu=%h rd=%0d rw=%b exp alu=10 rd=3 rw=1", wb_alu, wb_rd, wb_reg_write);
    end
    // Random ALU ops with stray acks that must be ignored.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a = $urandom;
      logic [4:0]  r = 5'($urandom);
      logic        m = 1'($urandom);
      logic        w = 1'($urandom);
      set_ex(1'b0, 1'b0, a, $urandom, r, m, w);
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      n_tests++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL alu_rand_stall[%0d] got %b exp 0", i, stall);
      end
      step();
      n_tests++;
      if ({wb_alu, wb_rd, wb_mem_to_reg, wb_reg_write, wb_rdata, dmem_req} !== {a, r, m, w, exp_rdata, 1'b0}) begin
        n_fail++;
        $display("FAIL alu_rand_wb[%0d] got alu=%h rd=%0d m2r=%b rw=%b rdata=%h req=%b exp alu=%h rd=%0d m2r=%b rw=%b rdata=%h req=0",
                 i, wb_alu, wb_rd, wb_mem_to_reg, wb_reg_write, wb_rdata, dmem_req, a, r, m, w, exp_rdata);
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_load();
    do_access("load_2wait", 1'b0, 1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 2, 32'hDEAD_BEEF);
    do_access("load_max_wait", 1'b0, 1'b1, 32'h104, 32'h0, 5'd9, 1'b1, 1'b1, TO - 1, 32'h1234_5678);
  endtask

  task automatic test_store();
    do_access("store_imm", 1'b1, 1'b0, 32'h200, 32'h55, 5'd4, 1'b0, 1'b0, 0, 32'hCAFE_F00D);
    do_access("store_rd_both", 1'b1, 1'b1, 32'h204, 32'hA5A5_0001, 5'd6, 1'b0, 1'b0, 1, 32'h0BAD_0BAD);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic        wr = 1'($urandom);
      logic [31:0] a  = $urandom & 32'hFFFF_FFFC;
      do_access($sformatf("rand_access[%0d]", i), wr, ~wr, a, $urandom, 5'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 6)), $urandom);
    end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    set_ex(1'b1, 1'b0, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1);
    #1;
    n_tests++;
    if ({misalign, stall} !== 2'b10) begin
      n_fail++; $display("FAIL misalign_pulse got misalign=%b stall=%b exp 1 0", misalign, stall);
    end
    step();
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if ({dmem_req, wb_reg_write, misalign} !== 3'b000) begin
      n_fail++; $display("FAIL misalign_trap got req=%b rw=%b misalign=%b exp 0 0 0", dmem_req, wb_reg_write, misalign);
    end
    step();
`else
    do_access("unaligned_load", 1'b0, 1'b1, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1, 32'h0F0F_0F0F);
`endif
  endtask

  task automatic test_timeout();
    set_ex(1'b1, 1'b0, 32'h300, 32'h0, 5'd2, 1'b1, 1'b1);
    dmem_ack = 1'b0;
    step();
    for (int i = 0; i < TO; i++) begin
      n_tests++;
      if ({dmem_req, bus_err, stall} !== 3'b101) begin
        n_fail++; $display("FAIL timeout_wait[%0d] got req=%b berr=%b stall=%b exp 1 0 1", i, dmem_req, bus_err, stall);
      end
      step();
    end
    n_tests++;
    if ({bus_err, stall, dmem_req, wb_reg_write} !== 4'b1100) begin
      n_fail++; $display("FAIL timeout_err got berr=%b stall=%b req=%b rw=%b exp 1 1 0 0", bus_err, stall, dmem_req, wb_reg_write);
    end
    dmem_ack = 1'b1;
    set_ex(1'b0, 1'b0, 32'h44, 32'h0, 5'd1, 1'b0, 1'b1);
    step(); step(); step();
    n_tests++;
    if ({bus_err, stall, dmem_req, wb_reg_write} !== 4'b1100) begin
      n_fail++; $display("FAIL err_sticky got berr=%b stall=%b req=%b rw=%b exp 1 1 0 0", bus_err, stall, dmem_req, wb_reg_write);
    end
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    step();
    rst = 1'b0;
    #1;
    exp_rdata = 32'h0;
    n_tests++;
    if (any_out() !== 1'b0) begin
      n_fail++; $display("FAIL err_reset got berr=%b stall=%b nonzero outputs exp all 0", bus_err, stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_ex(1'b1, 1'b0, 32'h400, 32'h0, 5'd5, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_req got %b exp 0", dmem_req);
    end
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_1111;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_stall got %b exp 0", stall);
    end
    step();
    dmem_ack = 1'b0;
    n_tests++;
    if (any_out() !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_ack got req=%b rdata=%h rw=%b exp all 0", dmem_req, wb_rdata, wb_reg_write);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_stage

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in WAIT without dmem_ack before bus error; range 1..255.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 alu_res  in  32  effective address / ALU result from EX/MEM.
REQ-006 st_data  in  32  store data from EX/MEM.
REQ-007 rd  in  5  destination register from EX/MEM.
REQ-008 mem_read, mem_write, mem_to_reg, reg_write  in  1 each  EX/MEM control bits.
REQ-009 dmem_req  out  1  data-memory request.
REQ-010 dmem_we  out  1  request is a write.
REQ-011 dmem_addr  out  32  word address.
REQ-012 dmem_wdata  out  32  write data.
REQ-013 dmem_ack  in  1  memory completion.
REQ-014 dmem_rdata  in  32  read data; valid only with dmem_ack.
REQ-015 stall  out  1  hold EX/MEM and earlier stages.
REQ-016 wb_rdata, wb_alu  out  32 each  MEM/WB load data and ALU result.
REQ-017 wb_rd  out  5; wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB fields.
REQ-018 bus_err  out  1  sticky timeout flag.
REQ-019 misalign  out  1  one-cycle misaligned-access pulse.

Function
REQ-020 FSM states: IDLE, WAIT, ERR.
REQ-021 Access = mem_read | mem_write; mem_write takes priority when both are set.
REQ-022 IDLE, no access: stall=0; MEM/WB loads alu_res, rd, mem_to_reg, reg_write at the edge; wb_rdata holds its value.
REQ-023 IDLE, access: stall=1 combinationally; the edge registers dmem_req=1, dmem_we, dmem_addr, dmem_wdata; next state WAIT; MEM/WB loads a bubble (wb_reg_write=0).
REQ-024 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata stay stable; stall = !dmem_ack.
REQ-025 WAIT with dmem_ack: at the edge, MEM/WB loads dmem_rdata (loads only) and the EX/MEM fields, dmem_req drops, next state IDLE. Minimum latency: access seen in cycle N, ack in N+1, WB valid in N+2.
REQ-026 WAIT: an 8-bit counter increments each cycle without ack; when it reaches TIMEOUT, next state ERR.
REQ-027 ERR: dmem_req=0, stall=1, bus_err=1; only reset exits ERR.
REQ-028 While stall=1, wb_reg_write is loaded 0 every edge, so a held instruction is never written back twice.
REQ-029 dmem_ack outside WAIT is ignored.
REQ-030 Stores load MEM/WB with the store's own reg_write, normally 0.

Reset
REQ-031 rst=1 at an edge forces state=IDLE, counter=0, and all outputs 0.
REQ-032 Reset mid-WAIT drops dmem_req at that edge; a late ack is then ignored.
REQ-033 Reset clears bus_err.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN defined: an access with alu_res[1:0]!=0 issues no request, pulses misalign for that cycle, loads a bubble into MEM/WB, and keeps stall=0.
REQ-035 Macro MISALIGN_TRAP_EN undefined: dmem_addr={alu_res[31:2],2'b00}; misalign is tied 0.

Structure
REQ-036 Shared package mips_pkg SHALL hold the FSM state enum, DATA_W=32 and REG_ADDR_W=5.
REQ-037 The MEM/WB register is a sub-module mem_wb with load and bubble controls; the FSM, counter and request registers stay in mem_stage.

Verification
REQ-038 ALU op: alu_res=0x10, rd=3, reg_write=1, no access -> next edge wb_alu=0x10, wb_rd=3, wb_reg_write=1, stall=0.
REQ-039 Load, ack after 2 cycles with rdata=0xDEADBEEF, alu_res=0x100 -> dmem_addr=0x100, stall high 3 cycles, then wb_rdata=0xDEADBEEF, wb_reg_write=1 exactly once.
REQ-040 Store, alu_res=0x200, st_data=0x55, immediate ack -> dmem_we=1, dmem_wdata=0x55, one request cycle, wb_reg_write=0.
REQ-041 No ack for TIMEOUT=15 cycles -> bus_err=1, stall stuck 1, dmem_req=0; rst -> all outputs 0.
REQ-042 rst asserted in WAIT, then ack next cycle -> dmem_req=0 and MEM/WB unchanged from reset value.
REQ-043 With MISALIGN_TRAP_EN, load at 0x102 -> misalign pulse 1 cycle, no dmem_req, wb_reg_write=0, stall=0.
